// File: rtl/gray_seq_gen.sv
// gray_seq_gen: binary up/down counter presented as a registered binary/Gray pair
// on a ready/valid stream. It sits directly upstream of the Gray-code consumers.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous, active-high reset
//   start    - pulse: begin streaming (IDLE -> RUN)
//   stop     - pulse: stop streaming (RUN -> IDLE); wins over start
//   up       - direction, sampled only on an advance (1 = increment)
//   load     - load load_val into the count at the next edge, in any state
//   load_val - binary seed value
//   b_out    - registered binary count
//   g_out    - registered Gray code of b_out
//   g_valid  - g_out is offered to the consumer (high in RUN)
//   g_ready  - consumer accepts g_out
//   wrap     - one-cycle pulse after an advance across the terminal count
//   adj_err  - sticky flag: an advance changed other than exactly one Gray bit
module gray_seq_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] g_out,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             wrap,
  output logic             adj_err
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             adj_err_q, adj_err_d;

  logic             valid;
  logic             advance;
  logic             step;
  logic [WIDTH-1:0] gray_diff;
  int unsigned      diff_ones;

  assign valid   = (state_q == StRun);
  assign advance = valid & g_ready;
  // A load consumes the offered word but replaces the step.
  assign step    = advance & ~load;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && !stop) state_d = StRun;
      StRun:  if (stop)           state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  always_comb begin
    bin_d = bin_q;
    if (load) begin
      bin_d = load_val;
    end else if (advance) begin
      bin_d = up ? (bin_q + One) : (bin_q - One);
    end
  end

  // Gray is derived from the next binary value so both registers load together.
  assign gray_d = bin_d ^ (bin_d >> 1);

  always_comb begin
    wrap_d = 1'b0;
    if (step) begin
      wrap_d = up ? (bin_q == AllOnes) : (bin_q == '0);
    end
  end

  assign gray_diff = gray_q ^ gray_d;

  always_comb begin
    diff_ones = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      diff_ones = diff_ones + 32'(gray_diff[i]);
    end
  end

  always_comb begin
    adj_err_d = adj_err_q;
    if (step && (diff_ones != 1)) adj_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      gray_q    <= '0;
      wrap_q    <= 1'b0;
      adj_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      wrap_q    <= wrap_d;
      adj_err_q <= adj_err_d;
    end
  end

  assign b_out   = bin_q;
  assign g_out   = gray_q;
  assign g_valid = valid;
  assign wrap    = wrap_q;
  assign adj_err = adj_err_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed bench for gray_seq_gen (WIDTH = 4). Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point.
module tb_gray_seq_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] b_out;
  logic [3:0] g_out;
  logic       g_valid;
  logic       g_ready;
  logic       wrap;
  logic       adj_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_seq_gen #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .b_out    (b_out),
    .g_out    (g_out),
    .g_valid  (g_valid),
    .g_ready  (g_ready),
    .wrap     (wrap),
    .adj_err  (adj_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".b_out"},   32'(b_out),   32'h0);
    check_eq({tag, ".g_out"},   32'(g_out),   32'h0);
    check_eq({tag, ".g_valid"}, 32'(g_valid), 32'h0);
    check_eq({tag, ".wrap"},    32'(wrap),    32'h0);
    check_eq({tag, ".adj_err"}, 32'(adj_err), 32'h0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; up = 1'b1;
    load = 1'b0; load_val = 4'd0; g_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_all_zero("reset_async");
    step();
    check_all_zero("reset_clocked");
    rst = 1'b0;
    step();
    check_eq("idle_no_start.g_valid", 32'(g_valid), 32'h0);

    // 1: full up sequence with wrap
    up = 1'b1; g_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("up_seq[%0d].g_out", i), 32'(g_out), 32'(gray_tab[i]));
      check_eq($sformatf("up_seq[%0d].b_out", i), 32'(b_out), i);
      check_eq($sformatf("up_seq[%0d].g_valid", i), 32'(g_valid), 32'h1);
      check_eq($sformatf("up_seq[%0d].wrap", i), 32'(wrap), 32'h0);
      step();
    end
    check_eq("up_wrap.g_out", 32'(g_out), 32'h0);
    check_eq("up_wrap.wrap", 32'(wrap), 32'h1);
    check_eq("up_wrap.adj_err", 32'(adj_err), 32'h0);
    step();
    check_eq("up_wrap_end.wrap", 32'(wrap), 32'h0);
    check_eq("up_wrap_end.b_out", 32'(b_out), 32'h1);

    // 2: backpressure at b_out=5, with up toggled during the stall
    repeat (4) step();
    check_eq("bp_pre.g_out", 32'(g_out), 32'b0111);
    g_ready = 1'b0; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("bp_hold[%0d].g_out", i), 32'(g_out), 32'b0111);
      check_eq($sformatf("bp_hold[%0d].b_out", i), 32'(b_out), 32'd5);
    end
    up = 1'b1; g_ready = 1'b1;
    step();
    check_eq("bp_release.g_out", 32'(g_out), 32'b0101);
    check_eq("bp_release.b_out", 32'(b_out), 32'd6);
    step();
    check_eq("bp_nobubble.b_out", 32'(b_out), 32'd7);
    check_eq("bp_nobubble.g_valid", 32'(g_valid), 32'h1);

    // 5b: stop during a handshake at b_out=7
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("stop_hs.b_out", 32'(b_out), 32'd8);
    check_eq("stop_hs.g_out", 32'(g_out), 32'b1100);
    check_eq("stop_hs.g_valid", 32'(g_valid), 32'h0);
    step();
    check_eq("idle_frozen.b_out", 32'(b_out), 32'd8);

    // 5a: start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_eq("start_stop.g_valid", 32'(g_valid), 32'h0);
    step();
    check_eq("start_stop_after.g_valid", 32'(g_valid), 32'h0);

    // 3: down count from a seed of 1, loaded while idle
    load = 1'b1; load_val = 4'd1; up = 1'b0;
    step();
    load = 1'b0;
    check_eq("load_idle.b_out", 32'(b_out), 32'd1);
    check_eq("load_idle.g_valid", 32'(g_valid), 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("down[0].g_out", 32'(g_out), 32'b0001);
    check_eq("down[0].g_valid", 32'(g_valid), 32'h1);
    step();
    check_eq("down[1].b_out", 32'(b_out), 32'd0);
    check_eq("down[1].g_out", 32'(g_out), 32'b0000);
    check_eq("down[1].wrap", 32'(wrap), 32'h0);
    step();
    check_eq("down[2].b_out", 32'(b_out), 32'd15);
    check_eq("down[2].g_out", 32'(g_out), 32'b1000);
    check_eq("down[2].wrap", 32'(wrap), 32'h1);
    step();
    check_eq("down[3].b_out", 32'(b_out), 32'd14);
    check_eq("down[3].wrap", 32'(wrap), 32'h0);

    // 4: load collides with a handshake at b_out=3
    g_ready = 1'b0; load = 1'b1; load_val = 4'd3;
    step();
    check_eq("load_run.b_out", 32'(b_out), 32'd3);
    check_eq("load_run.g_out", 32'(g_out), 32'b0010);
    check_eq("load_run.g_valid", 32'(g_valid), 32'h1);
    load_val = 4'd10; g_ready = 1'b1; up = 1'b1;
    step();
    load = 1'b0;
    check_eq("load_hs.b_out", 32'(b_out), 32'd10);
    check_eq("load_hs.g_out", 32'(g_out), 32'b1111);
    check_eq("load_hs.wrap", 32'(wrap), 32'h0);
    check_eq("load_hs.adj_err", 32'(adj_err), 32'h0);
    step();
    check_eq("after_load.b_out", 32'(b_out), 32'd11);
    check_eq("after_load.g_out", 32'(g_out), 32'b1110);
    check_eq("after_load.adj_err", 32'(adj_err), 32'h0);

    // 6: asynchronous reset between edges
    #3 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    #2 rst = 1'b0;
    step();
    check_eq("post_rst.g_valid", 32'(g_valid), 32'h0);
    check_eq("post_rst.b_out", 32'(b_out), 32'h0);
    step();
    check_eq("post_rst_idle.b_out", 32'(b_out), 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("restart.g_valid", 32'(g_valid), 32'h1);
    check_eq("restart.b_out", 32'(b_out), 32'h0);
    step();
    check_eq("restart_adv.b_out", 32'(b_out), 32'h1);
    check_eq("restart_adv.g_out", 32'(g_out), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
